// File: rtl/wavelet_pkg.sv
// Shared definitions for the wavelet soft-threshold block.
//   - default widths and derived log2 sizes
//   - threshold FSM state encoding
//   - sat_unsigned(): clamp an unsigned value to a given bit width
package wavelet_pkg;

    localparam int ADC_WIDTH_DEF       = 14;
    localparam int MAX_WINDOW_SIZE_DEF = 1024;
    localparam int SCALE_W_DEF         = 16;
    localparam int FRAC_BITS_DEF       = 12;

    localparam int ADC_WIDTH_LOG  = $clog2(ADC_WIDTH_DEF);
    localparam int MAX_WINDOW_LOG = $clog2(MAX_WINDOW_SIZE_DEF);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL1 = 3'd1,
        ST_MUL2 = 3'd2,
        ST_SAT  = 3'd3,
        ST_LOAD = 3'd4
    } thr_state_t;

    // Clamp value to the largest number representable in 'width' bits.
    function automatic logic [63:0] sat_unsigned(input logic [63:0] value,
                                                 input int unsigned width);
        logic [63:0] limit;
        limit = (64'd1 << width) - 64'd1;
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/soft_thr_pipe.sv
// Three-stage soft-threshold datapath.
//   S1: sign, |x| (one extra bit so the most negative input is safe),
//       threshold and enable sampled per sample
//   S2: d = |x| - T (signed, two extra bits)
//   S3: m = max(d, 0), y = sign ? -m : m, or y = x when bypassed
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   detail_in/valid   signed input coefficient and qualifier
//   threshold         active threshold T (unsigned)
//   denoised_en       1 = threshold, 0 = pass through
//   detail_out/valid  signed result and qualifier, 3 cycles after input
//   zero_flag         1 while a thresholded sample leaving S3 was zeroed
module soft_thr_pipe
    import wavelet_pkg::*;
#(
    parameter int ADC_WIDTH = ADC_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADC_WIDTH-1:0] detail_in,
    input  logic                 detail_valid_in,
    input  logic [ADC_WIDTH-1:0] threshold,
    input  logic                 denoised_en,
    output logic [ADC_WIDTH-1:0] detail_out,
    output logic                 detail_valid_out,
    output logic                 zero_flag
);

    // ---------------- stage 1 ----------------
    logic [ADC_WIDTH:0]   x_ext;
    logic [ADC_WIDTH:0]   abs_next;
    logic                 valid_s1_reg;
    logic                 sign_s1_reg;
    logic [ADC_WIDTH:0]   abs_s1_reg;
    logic [ADC_WIDTH-1:0] thr_s1_reg;
    logic                 en_s1_reg;
    logic [ADC_WIDTH-1:0] raw_s1_reg;

    assign x_ext    = {detail_in[ADC_WIDTH-1], detail_in};
    assign abs_next = detail_in[ADC_WIDTH-1] ? -x_ext : x_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s1_reg <= 1'b0;
            sign_s1_reg  <= 1'b0;
            abs_s1_reg   <= '0;
            thr_s1_reg   <= '0;
            en_s1_reg    <= 1'b0;
            raw_s1_reg   <= '0;
        end else begin
            valid_s1_reg <= detail_valid_in;
            sign_s1_reg  <= detail_in[ADC_WIDTH-1];
            abs_s1_reg   <= abs_next;
            thr_s1_reg   <= threshold;
            en_s1_reg    <= denoised_en;
            raw_s1_reg   <= detail_in;
        end
    end

    // ---------------- stage 2 ----------------
    logic signed [ADC_WIDTH+1:0] diff_next;
    logic                        valid_s2_reg;
    logic                        sign_s2_reg;
    logic signed [ADC_WIDTH+1:0] diff_s2_reg;
    logic                        en_s2_reg;
    logic [ADC_WIDTH-1:0]        raw_s2_reg;

    assign diff_next = $signed({1'b0, abs_s1_reg}) - $signed({2'b00, thr_s1_reg});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_s2_reg <= 1'b0;
            sign_s2_reg  <= 1'b0;
            diff_s2_reg  <= '0;
            en_s2_reg    <= 1'b0;
            raw_s2_reg   <= '0;
        end else begin
            valid_s2_reg <= valid_s1_reg;
            sign_s2_reg  <= sign_s1_reg;
            diff_s2_reg  <= diff_next;
            en_s2_reg    <= en_s1_reg;
            raw_s2_reg   <= raw_s1_reg;
        end
    end

    // ---------------- stage 3 ----------------
    logic [ADC_WIDTH:0]   mag;
    logic [ADC_WIDTH:0]   y_full;
    logic [ADC_WIDTH-1:0] y_next;
    logic                 zero_next;
    logic                 y_msb_unused;

    // d is positive here only when |x| > T, so m <= 2^(ADC_WIDTH-1) and
    // sign * m always fits back into ADC_WIDTH bits; the top bit is redundant.
    assign mag          = (diff_s2_reg <= 0) ? '0 : diff_s2_reg[ADC_WIDTH:0];
    assign y_full       = sign_s2_reg ? -mag : mag;
    assign y_msb_unused = y_full[ADC_WIDTH];
    assign y_next       = en_s2_reg ? y_full[ADC_WIDTH-1:0] : raw_s2_reg;
    assign zero_next    = valid_s2_reg && en_s2_reg && (mag == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            detail_out       <= '0;
            detail_valid_out <= 1'b0;
            zero_flag        <= 1'b0;
        end else begin
            detail_valid_out <= valid_s2_reg;
            zero_flag        <= zero_next;
            if (valid_s2_reg) begin
                detail_out <= y_next;
            end
        end
    end

endmodule

// File: rtl/wavelet_soft_threshold.sv
// Soft thresholding of a wavelet detail-coefficient stream.
// A lock pulse latches the median estimate; a small FSM turns it into
// T = sat((median * thr_scale_cfg) >> FRAC_BITS) and loads it as the active
// threshold 4 cycles after the lock. Each sample becomes sign(x)*max(|x|-T,0)
// after a fixed 3-cycle pipeline. The number of zeroed samples between locks
// is reported on zero_cnt_out.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   median_in             unsigned median, valid with lock_median_posedge
//   lock_median_posedge   1-cycle lock pulse
//   thr_scale_cfg         unsigned fixed-point threshold multiplier
//   denoised_en           1 = threshold, 0 = bypass (sampled at S1)
//   detail_in/valid_in    signed input coefficient and qualifier
//   detail_out/valid_out  thresholded coefficient and qualifier
//   threshold_out         active threshold T
//   thr_valid             set once the first threshold has been loaded
//   zero_cnt_out          zeroed-sample count of the previous window
module wavelet_soft_threshold
    import wavelet_pkg::*;
#(
    parameter int ADC_WIDTH       = ADC_WIDTH_DEF,
    parameter int MAX_WINDOW_SIZE = MAX_WINDOW_SIZE_DEF,
    parameter int SCALE_W         = SCALE_W_DEF,
    parameter int FRAC_BITS       = FRAC_BITS_DEF
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [ADC_WIDTH:0]                 median_in,
    input  logic                               lock_median_posedge,
    input  logic [SCALE_W-1:0]                 thr_scale_cfg,
    input  logic                               denoised_en,
    input  logic [ADC_WIDTH-1:0]               detail_in,
    input  logic                               detail_valid_in,
    output logic [ADC_WIDTH-1:0]               detail_out,
    output logic                               detail_valid_out,
    output logic [ADC_WIDTH-1:0]               threshold_out,
    output logic                               thr_valid,
    output logic [$clog2(MAX_WINDOW_SIZE):0]   zero_cnt_out
);

    localparam int CNT_W  = $clog2(MAX_WINDOW_SIZE) + 1;
    localparam int PROD_W = ADC_WIDTH + 1 + SCALE_W;

    thr_state_t state_reg, state_next;

    logic                 load_op;
    logic                 op_from_pending;
    logic                 pend_set;
    logic                 pending_reg;
    logic [ADC_WIDTH:0]   pend_med_reg;
    logic [ADC_WIDTH:0]   med_op_reg;
    logic [SCALE_W-1:0]   scale_op_reg;
    logic [PROD_W-1:0]    mul_reg;
    logic [PROD_W-1:0]    prod_reg;
    logic [ADC_WIDTH-1:0] shadow_reg;
    logic [ADC_WIDTH-1:0] threshold_reg;
    logic                 thr_valid_reg;
    logic [CNT_W-1:0]     cnt_reg;
    logic [CNT_W-1:0]     zero_cnt_reg;
    logic                 zero_flag;
    logic [63:0]          sat_full;
    logic                 sat_unused_bits;

    // ---------------- threshold FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        load_op         = 1'b0;
        op_from_pending = 1'b0;
        pend_set        = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (lock_median_posedge) begin
                    state_next = ST_MUL1;
                    load_op    = 1'b1;
                end
            end
            ST_MUL1: begin
                state_next = ST_MUL2;
                pend_set   = lock_median_posedge;
            end
            ST_MUL2: begin
                state_next = ST_SAT;
                pend_set   = lock_median_posedge;
            end
            ST_SAT: begin
                state_next = ST_LOAD;
                pend_set   = lock_median_posedge;
            end
            ST_LOAD: begin
                // A lock arriving right now is newer than anything pending,
                // so it is used directly and the pending value is discarded.
                if (lock_median_posedge) begin
                    state_next = ST_MUL1;
                    load_op    = 1'b1;
                end else if (pending_reg) begin
                    state_next      = ST_MUL1;
                    load_op         = 1'b1;
                    op_from_pending = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ---------------- threshold computation ----------------
    assign sat_full        = sat_unsigned(64'(prod_reg >> FRAC_BITS), ADC_WIDTH);
    assign sat_unused_bits = ^sat_full[63:ADC_WIDTH];

    // The multiply is registered twice (MUL1 -> mul_reg, MUL2 -> prod_reg)
    // so it maps onto a DSP block with both its pipeline registers used.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg   <= 1'b0;
            pend_med_reg  <= '0;
            med_op_reg    <= '0;
            scale_op_reg  <= '0;
            mul_reg       <= '0;
            prod_reg      <= '0;
            shadow_reg    <= '0;
            threshold_reg <= '0;
            thr_valid_reg <= 1'b0;
        end else begin
            if (pend_set) begin
                pending_reg  <= 1'b1;
                pend_med_reg <= median_in;
            end else if (load_op) begin
                pending_reg <= 1'b0;
            end

            if (load_op) begin
                med_op_reg   <= op_from_pending ? pend_med_reg : median_in;
                scale_op_reg <= thr_scale_cfg;
            end

            if (state_reg == ST_MUL1) begin
                mul_reg <= PROD_W'(med_op_reg) * PROD_W'(scale_op_reg);
            end
            if (state_reg == ST_MUL2) begin
                prod_reg <= mul_reg;
            end
            if (state_reg == ST_SAT) begin
                shadow_reg <= sat_full[ADC_WIDTH-1:0];
            end
            if (state_reg == ST_LOAD) begin
                threshold_reg <= shadow_reg;
                thr_valid_reg <= 1'b1;
            end
        end
    end

    // ---------------- zero counter ----------------
    // A zeroed sample leaving the pipe on the lock cycle belongs to the new
    // window. The running count sticks at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            zero_cnt_reg <= '0;
        end else if (lock_median_posedge) begin
            zero_cnt_reg <= cnt_reg;
            cnt_reg      <= zero_flag ? CNT_W'(1) : '0;
        end else if (zero_flag && (cnt_reg != {CNT_W{1'b1}})) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // ---------------- datapath ----------------
    soft_thr_pipe #(
        .ADC_WIDTH (ADC_WIDTH)
    ) u_pipe (
        .clk              (clk),
        .rst              (rst),
        .detail_in        (detail_in),
        .detail_valid_in  (detail_valid_in),
        .threshold        (threshold_reg),
        .denoised_en      (denoised_en),
        .detail_out       (detail_out),
        .detail_valid_out (detail_valid_out),
        .zero_flag        (zero_flag)
    );

    assign threshold_out = threshold_reg;
    assign thr_valid     = thr_valid_reg;
    assign zero_cnt_out  = zero_cnt_reg;

endmodule

// File: tb/tb_wavelet_soft_threshold.sv
module tb_wavelet_soft_threshold;

    logic        clk;
    logic        rst;
    logic [14:0] median_in;
    logic        lock_median_posedge;
    logic [15:0] thr_scale_cfg;
    logic        denoised_en;
    logic [13:0] detail_in;
    logic        detail_valid_in;
    logic [13:0] detail_out;
    logic        detail_valid_out;
    logic [13:0] threshold_out;
    logic        thr_valid;
    logic [10:0] zero_cnt_out;

    int checks;
    int failures;

    wavelet_soft_threshold dut (
        .clk                 (clk),
        .rst                 (rst),
        .median_in           (median_in),
        .lock_median_posedge (lock_median_posedge),
        .thr_scale_cfg       (thr_scale_cfg),
        .denoised_en         (denoised_en),
        .detail_in           (detail_in),
        .detail_valid_in     (detail_valid_in),
        .detail_out          (detail_out),
        .detail_valid_out    (detail_valid_out),
        .threshold_out       (threshold_out),
        .thr_valid           (thr_valid),
        .zero_cnt_out        (zero_cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are changed and outputs observed 1 ns after the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({detail_out, detail_valid_out, threshold_out, thr_valid, zero_cnt_out} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got out=%0d vld=%0b T=%0d tv=%0b zc=%0d, expected all 0",
                     detail_out, detail_valid_out, threshold_out, thr_valid, zero_cnt_out);
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs checked under reset");
    endtask

    task automatic test_first_lock;
        median_in = 15'd100;
        thr_scale_cfg = 16'h1C00;
        lock_median_posedge = 1'b1;
        tick();
        lock_median_posedge = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (threshold_out !== 14'd0 || thr_valid !== 1'b0) begin
                failures++;
                $display("FAIL lock_latency_early: cycle %0d T=%0d tv=%0b, expected T=0 tv=0",
                         i, threshold_out, thr_valid);
            end
        end
        tick();
        checks++;
        if (threshold_out !== 14'd175) begin
            failures++;
            $display("FAIL first_threshold: got %0d expected 175", threshold_out);
        end
        checks++;
        if (thr_valid !== 1'b1) begin
            failures++;
            $display("FAIL thr_valid_set: got %0b expected 1", thr_valid);
        end
        $display("first_lock: median=100 scale=0x1C00 T=%0d tv=%0b", threshold_out, thr_valid);
    endtask

    task automatic test_back_to_back;
        int xs [4];
        int ys [4];
        logic [13:0] exp_y;
        xs = '{300, -300, 150, -8192};
        ys = '{125, -125, 0, -8017};
        for (int i = 0; i <= 6; i++) begin
            if (i < 4) begin
                detail_in = 14'(xs[i]);
                detail_valid_in = 1'b1;
            end else begin
                detail_valid_in = 1'b0;
            end
            tick();
            if (i == 1 || i == 6) begin
                checks++;
                if (detail_valid_out !== 1'b0) begin
                    failures++;
                    $display("FAIL b2b_no_valid: step %0d valid_out=%0b expected 0", i, detail_valid_out);
                end
            end else if (i >= 2) begin
                exp_y = 14'(ys[i-2]);
                checks++;
                if (detail_valid_out !== 1'b1 || detail_out !== exp_y) begin
                    failures++;
                    $display("FAIL b2b_sample: in=%0d got y=%0d vld=%0b expected y=%0d vld=1",
                             xs[i-2], $signed(detail_out), detail_valid_out, ys[i-2]);
                end
                $display("back_to_back: in=%0d out=%0d", xs[i-2], $signed(detail_out));
            end
        end
        median_in = 15'd100;
        lock_median_posedge = 1'b1;
        tick();
        lock_median_posedge = 1'b0;
        checks++;
        if (zero_cnt_out !== 11'd1) begin
            failures++;
            $display("FAIL b2b_zero_count: got %0d expected 1", zero_cnt_out);
        end
        repeat (5) tick();
        $display("back_to_back: zero_cnt_out=%0d", zero_cnt_out);
    endtask

    task automatic test_saturation;
        int xs [3];
        xs = '{8191, -8192, 1};
        median_in = 15'd16383;
        thr_scale_cfg = 16'hFFFF;
        lock_median_posedge = 1'b1;
        tick();
        lock_median_posedge = 1'b0;
        repeat (4) tick();
        checks++;
        if (threshold_out !== 14'd16383) begin
            failures++;
            $display("FAIL sat_threshold: got %0d expected 16383", threshold_out);
        end
        thr_scale_cfg = 16'h1C00;
        for (int i = 0; i <= 4; i++) begin
            if (i < 3) begin
                detail_in = 14'(xs[i]);
                detail_valid_in = 1'b1;
            end else begin
                detail_valid_in = 1'b0;
            end
            tick();
            if (i >= 2) begin
                checks++;
                if (detail_valid_out !== 1'b1 || detail_out !== 14'd0) begin
                    failures++;
                    $display("FAIL sat_sample: in=%0d got y=%0d vld=%0b expected y=0 vld=1",
                             xs[i-2], $signed(detail_out), detail_valid_out);
                end
                $display("saturation: in=%0d out=%0d", xs[i-2], $signed(detail_out));
            end
        end
        repeat (2) tick();
    endtask

    task automatic test_pending_lock;
        median_in = 15'd100;
        lock_median_posedge = 1'b1;
        tick();                                  // E0
        lock_median_posedge = 1'b0;
        checks++;
        if (zero_cnt_out !== 11'd3) begin
            failures++;
            $display("FAIL pend_zero_count: got %0d expected 3", zero_cnt_out);
        end
        tick();                                  // E1
        median_in = 15'd200;
        lock_median_posedge = 1'b1;
        tick();                                  // E2
        lock_median_posedge = 1'b0;
        checks++;
        if (zero_cnt_out !== 11'd0) begin
            failures++;
            $display("FAIL pend_zero_clear: got %0d expected 0", zero_cnt_out);
        end
        tick();                                  // E3
        checks++;
        if (threshold_out !== 14'd16383) begin
            failures++;
            $display("FAIL pend_old_T: got %0d expected 16383", threshold_out);
        end
        tick();                                  // E4
        checks++;
        if (threshold_out !== 14'd175) begin
            failures++;
            $display("FAIL pend_first_T: got %0d expected 175", threshold_out);
        end
        repeat (3) tick();                       // E7
        checks++;
        if (threshold_out !== 14'd175) begin
            failures++;
            $display("FAIL pend_hold_T: got %0d expected 175", threshold_out);
        end
        tick();                                  // E8
        checks++;
        if (threshold_out !== 14'd350) begin
            failures++;
            $display("FAIL pend_second_T: got %0d expected 350", threshold_out);
        end
        $display("pending_lock: T=%0d after pending pass", threshold_out);
        repeat (2) tick();
    endtask

    task automatic test_bypass_and_boundary;
        denoised_en = 1'b0;
        detail_in = 14'(-50);
        detail_valid_in = 1'b1;
        tick();
        detail_valid_in = 1'b0;
        denoised_en = 1'b1;
        tick();
        tick();
        checks++;
        if (detail_valid_out !== 1'b1 || detail_out !== 14'(-50)) begin
            failures++;
            $display("FAIL bypass_sample: got y=%0d vld=%0b expected y=-50 vld=1",
                     $signed(detail_out), detail_valid_out);
        end
        $display("bypass: in=-50 out=%0d", $signed(detail_out));
        // Zeroed sample leaves the pipe in the same cycle as a lock.
        detail_in = 14'd10;
        detail_valid_in = 1'b1;
        tick();
        detail_valid_in = 1'b0;
        tick();
        tick();
        checks++;
        if (detail_valid_out !== 1'b1 || detail_out !== 14'd0) begin
            failures++;
            $display("FAIL boundary_sample: got y=%0d vld=%0b expected y=0 vld=1",
                     $signed(detail_out), detail_valid_out);
        end
        median_in = 15'd200;
        lock_median_posedge = 1'b1;
        tick();
        lock_median_posedge = 1'b0;
        checks++;
        if (zero_cnt_out !== 11'd0) begin
            failures++;
            $display("FAIL bypass_not_counted: got %0d expected 0", zero_cnt_out);
        end
        repeat (5) tick();
        lock_median_posedge = 1'b1;
        tick();
        lock_median_posedge = 1'b0;
        checks++;
        if (zero_cnt_out !== 11'd1) begin
            failures++;
            $display("FAIL boundary_zero_count: got %0d expected 1", zero_cnt_out);
        end
        $display("boundary: zero_cnt_out=%0d", zero_cnt_out);
        repeat (5) tick();
    endtask

    task automatic test_reset_midflight;
        median_in = 15'd100;
        lock_median_posedge = 1'b1;
        detail_in = 14'd300;
        detail_valid_in = 1'b1;
        tick();                                  // MUL1, one sample in flight
        lock_median_posedge = 1'b0;
        detail_in = 14'(-300);
        tick();                                  // MUL2, two samples in flight
        detail_valid_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({detail_out, detail_valid_out, threshold_out, thr_valid, zero_cnt_out} !== '0) begin
            failures++;
            $display("FAIL midflight_reset: got out=%0d vld=%0b T=%0d tv=%0b zc=%0d, expected all 0",
                     detail_out, detail_valid_out, threshold_out, thr_valid, zero_cnt_out);
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (detail_valid_out !== 1'b0) begin
                failures++;
                $display("FAIL midflight_dropped: cycle %0d valid_out=%0b expected 0", i, detail_valid_out);
            end
        end
        median_in = 15'd100;
        lock_median_posedge = 1'b1;
        tick();
        lock_median_posedge = 1'b0;
        repeat (3) tick();
        checks++;
        if (threshold_out !== 14'd0 || thr_valid !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_early: T=%0d tv=%0b expected T=0 tv=0", threshold_out, thr_valid);
        end
        tick();
        checks++;
        if (threshold_out !== 14'd175 || thr_valid !== 1'b1) begin
            failures++;
            $display("FAIL post_reset_lock: T=%0d tv=%0b expected T=175 tv=1", threshold_out, thr_valid);
        end
        $display("reset_midflight: relock T=%0d tv=%0b", threshold_out, thr_valid);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        median_in = '0;
        lock_median_posedge = 1'b0;
        thr_scale_cfg = 16'h1000;
        denoised_en = 1'b1;
        detail_in = '0;
        detail_valid_in = 1'b0;

        test_reset();
        test_first_lock();
        test_back_to_back();
        test_saturation();
        test_pending_lock();
        test_bypass_and_boundary();
        test_reset_midflight();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
